// File: rtl/train_seq.sv
// Training sequencer: per sample drives forward/backward/update engines via
// start/done handshakes and reduces the per-sample |cost| to an epoch mean.
module train_seq #(
   parameter int WIDTH        = 24,
   parameter int LOG2_SAMPLES = 2,
   parameter int ACC_WIDTH    = 32,
   parameter int EPOCH_W      = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_start,
   input  logic                           i_abort,
   input  logic                           i_mode,
   input  logic        [EPOCH_W-1:0]      i_max_epochs,
   input  logic signed [WIDTH-1:0]        i_cost_thresh,
   output logic                           o_fwd_start,
   output logic                           o_bwd_start,
   output logic                           o_upd_start,
   input  logic                           i_fwd_done,
   input  logic                           i_bwd_done,
   input  logic                           i_upd_done,
   input  logic signed [WIDTH-1:0]        i_sample_cost,
   output logic        [LOG2_SAMPLES-1:0] o_sample_idx,
   output logic        [EPOCH_W-1:0]      o_epoch,
   output logic signed [WIDTH-1:0]        o_cost,
   output logic                           o_cost_valid,
   output logic                           o_busy,
   output logic                           o_stop,
   output logic                           o_converged
);

   typedef enum logic [2:0] {S_IDLE, S_FWD, S_BWD, S_UPD, S_EPOCH, S_DONE} state_t;

   localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [ACC_WIDTH-1:0]    AMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};

   state_t                    state_q, state_d;
   logic                      mode_q;
   logic [EPOCH_W-1:0]        max_q;
   logic signed [WIDTH-1:0]   thresh_q;
   logic [ACC_WIDTH-1:0]      acc_q;
   logic [LOG2_SAMPLES-1:0]   idx_q;
   logic [EPOCH_W-1:0]        epoch_q;
   logic signed [WIDTH-1:0]   cost_q;
   logic                      cost_vld_q, conv_q, busy_q, stop_q;
   logic                      fwd_start_q, bwd_start_q, upd_start_q;

   logic                      fwd_go, bwd_go, upd_go;
   logic [WIDTH-1:0]          cost_abs;
   logic [ACC_WIDTH-1:0]      acc_sum, acc_add, mean;
   logic signed [WIDTH-1:0]   mean_sat;
   logic [EPOCH_W-1:0]        epoch_inc;
   logic                      last, converge;

   // acc never has its MSB set, so the sum of two non-negatives cannot wrap
   always_comb begin
      cost_abs = (i_sample_cost == SMIN) ? SMAX :
                 (i_sample_cost[WIDTH-1] ? -i_sample_cost : i_sample_cost);
      acc_sum  = acc_q + {{(ACC_WIDTH-WIDTH){1'b0}}, cost_abs};
      acc_add  = acc_sum[ACC_WIDTH-1] ? AMAX : acc_sum;
      mean     = acc_q >> LOG2_SAMPLES;
      mean_sat = (mean > {{(ACC_WIDTH-WIDTH){1'b0}}, SMAX}) ? SMAX : mean[WIDTH-1:0];
      converge = (mean_sat <= thresh_q);
      epoch_inc = (epoch_q == '1) ? epoch_q : epoch_q + EPOCH_W'(1);
      last     = (idx_q == '1);
   end

   always_comb begin
      state_d = state_q;
      fwd_go  = 1'b0;
      bwd_go  = 1'b0;
      upd_go  = 1'b0;
      case (state_q)
         S_IDLE: if (i_start) begin
            state_d = S_FWD;
            fwd_go  = 1'b1;
         end
         S_FWD: if (i_abort) state_d = S_DONE;
            else if (i_fwd_done) begin
               if (!mode_q) begin
                  state_d = S_BWD;
                  bwd_go  = 1'b1;
               end else if (last) state_d = S_EPOCH;
               else begin
                  state_d = S_FWD;
                  fwd_go  = 1'b1;
               end
            end
         S_BWD: if (i_abort) state_d = S_DONE;
            else if (i_bwd_done) begin
               state_d = S_UPD;
               upd_go  = 1'b1;
            end
         S_UPD: if (i_abort) state_d = S_DONE;
            else if (i_upd_done) begin
               if (last) state_d = S_EPOCH;
               else begin
                  state_d = S_FWD;
                  fwd_go  = 1'b1;
               end
            end
         S_EPOCH: if (i_abort || converge || mode_q || epoch_inc == max_q) state_d = S_DONE;
            else begin
               state_d = S_FWD;
               fwd_go  = 1'b1;
            end
         S_DONE: if (!i_start) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         mode_q      <= 1'b0;
         max_q       <= '0;
         thresh_q    <= '0;
         acc_q       <= '0;
         idx_q       <= '0;
         epoch_q     <= '0;
         cost_q      <= '0;
         cost_vld_q  <= 1'b0;
         conv_q      <= 1'b0;
         busy_q      <= 1'b0;
         stop_q      <= 1'b0;
         fwd_start_q <= 1'b0;
         bwd_start_q <= 1'b0;
         upd_start_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         fwd_start_q <= fwd_go;
         bwd_start_q <= bwd_go;
         upd_start_q <= upd_go;
         busy_q      <= (state_d inside {S_FWD, S_BWD, S_UPD, S_EPOCH});
         stop_q      <= (state_d == S_DONE);
         cost_vld_q  <= (state_q == S_EPOCH);
         case (state_q)
            S_IDLE: if (i_start) begin
               mode_q   <= i_mode;
               max_q    <= (i_max_epochs == '0) ? EPOCH_W'(1) : i_max_epochs;
               thresh_q <= i_cost_thresh;
               acc_q    <= '0;
               idx_q    <= '0;
               epoch_q  <= '0;
               conv_q   <= 1'b0;
            end
            S_FWD: if (!i_abort && i_fwd_done) begin
               acc_q <= acc_add;
               if (mode_q && !last) idx_q <= idx_q + LOG2_SAMPLES'(1);
            end
            S_UPD: if (!i_abort && i_upd_done && !last) idx_q <= idx_q + LOG2_SAMPLES'(1);
            S_EPOCH: begin
               cost_q  <= mean_sat;
               epoch_q <= epoch_inc;
               acc_q   <= '0;
               idx_q   <= '0;
               conv_q  <= !i_abort && converge;
            end
            default: ;
         endcase
      end
   end

   assign o_fwd_start  = fwd_start_q;
   assign o_bwd_start  = bwd_start_q;
   assign o_upd_start  = upd_start_q;
   assign o_sample_idx = idx_q;
   assign o_epoch      = epoch_q;
   assign o_cost       = cost_q;
   assign o_cost_valid = cost_vld_q;
   assign o_busy       = busy_q;
   assign o_stop       = stop_q;
   assign o_converged  = conv_q;

endmodule

// File: tb/tb_train_seq.sv
// Directed bench for train_seq: a run-level model predicts start pulses,
// epoch costs and final status; a per-cycle monitor compares the DUT to it.
module tb_train_seq;
   localparam int W = 24, L = 2, A = 32, E = 16;
   localparam int NS = 1 << L;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic i_start = 0, i_abort = 0, i_mode = 0;
   logic [E-1:0] i_max_epochs = '0;
   logic signed [W-1:0] i_cost_thresh = '0, i_sample_cost = '0;
   logic i_fwd_done = 0, i_bwd_done = 0, i_upd_done = 0;
   logic o_fwd_start, o_bwd_start, o_upd_start, o_cost_valid, o_busy, o_stop, o_converged;
   logic [L-1:0] o_sample_idx;
   logic [E-1:0] o_epoch;
   logic signed [W-1:0] o_cost;

   train_seq #(.WIDTH(W), .LOG2_SAMPLES(L), .ACC_WIDTH(A), .EPOCH_W(E)) dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort), .i_mode(i_mode),
      .i_max_epochs(i_max_epochs), .i_cost_thresh(i_cost_thresh),
      .o_fwd_start(o_fwd_start), .o_bwd_start(o_bwd_start), .o_upd_start(o_upd_start),
      .i_fwd_done(i_fwd_done), .i_bwd_done(i_bwd_done), .i_upd_done(i_upd_done),
      .i_sample_cost(i_sample_cost), .o_sample_idx(o_sample_idx), .o_epoch(o_epoch),
      .o_cost(o_cost), .o_cost_valid(o_cost_valid), .o_busy(o_busy), .o_stop(o_stop),
      .o_converged(o_converged));

   int n_chk = 0, n_pass = 0;
   int exp_p[$];
   longint exp_c[$];
   longint model_cost = 0;
   int exp_epoch = 0;
   bit exp_conv = 0;
   int costs[NS];
   bit checking = 0, force_upd = 0;
   int cnt_f, cnt_b, cnt_u, cnt_v;
   int abort_at = 0, npulse = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   function automatic longint outs();
      return longint'({o_fwd_start, o_bwd_start, o_upd_start, o_sample_idx, o_epoch,
                       o_cost, o_cost_valid, o_busy, o_stop, o_converged});
   endfunction

   // Run-level model: pulse codes are engine*16+sample (1=fwd, 2=bwd, 3=upd)
   task automatic model_run(input bit mode, input int maxe, input longint thr, input int ab);
      int lim, np;
      longint sum, a, mean;
      lim = (maxe == 0) ? 1 : maxe;
      np = 0;
      exp_p.delete(); exp_c.delete();
      exp_conv = 0; exp_epoch = 0;
      for (int e = 1; e <= lim; e++) begin
         sum = 0;
         for (int s = 0; s < NS; s++) begin
            for (int k = 1; k <= (mode ? 1 : 3); k++) begin
               exp_p.push_back(k * 16 + s);
               np++;
               if (np == ab) return;
            end
            a = costs[s];
            if (a == -8388608) a = 8388607;
            else if (a < 0) a = -a;
            sum += a;
            if (sum > 2147483647) sum = 2147483647;
         end
         mean = sum / NS;
         if (mean > 8388607) mean = 8388607;
         exp_c.push_back(mean);
         model_cost = mean;
         exp_epoch = e;
         if (mean <= thr) begin exp_conv = 1; return; end
         if (mode) return;
      end
   endtask

   // Engines: each done follows its start by one cycle; abort raised on a chosen pulse
   initial begin
      bit pf, pb, pu;
      pf = 0; pb = 0; pu = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pf = 0; pb = 0; pu = 0;
            i_fwd_done = 0; i_bwd_done = 0; i_upd_done = 0;
         end else begin
            i_fwd_done = pf; i_bwd_done = pb; i_upd_done = pu | force_upd;
            pf = o_fwd_start; pb = o_bwd_start; pu = o_upd_start;
            i_sample_cost = W'(costs[o_sample_idx]);
            if (o_fwd_start | o_bwd_start | o_upd_start) npulse++;
            i_abort = (abort_at > 0 && npulse >= abort_at && o_busy);
         end
      end
   end

   // Monitor
   initial begin
      int n, code;
      forever begin
         @(negedge clk);
         if (checking && rst_n) begin
            n = int'(o_fwd_start) + int'(o_bwd_start) + int'(o_upd_start);
            chk("start_onehot", n <= 1, 1);
            if (n > 0) begin
               code = o_fwd_start ? 1 : (o_bwd_start ? 2 : 3);
               if (code == 1) cnt_f++; else if (code == 2) cnt_b++; else cnt_u++;
               code = code * 16 + int'(o_sample_idx);
               if (exp_p.size() == 0) chk("unexpected_pulse", code, 0);
               else chk("pulse", code, exp_p.pop_front());
            end
            if (o_cost_valid) begin
               cnt_v++;
               if (exp_c.size() == 0) chk("unexpected_cost", o_cost, -1);
               else chk("cost", o_cost, exp_c.pop_front());
            end
            chk("busy_stop_excl", o_busy & o_stop, 0);
         end
      end
   end

   task automatic do_run(input string nm, input bit mode, input int maxe, input longint thr, input int ab);
      bit seen;
      model_run(mode, maxe, thr, ab);
      @(negedge clk);
      cnt_f = 0; cnt_b = 0; cnt_u = 0; cnt_v = 0; npulse = 0; abort_at = ab;
      i_mode = mode; i_max_epochs = E'(maxe); i_cost_thresh = W'(thr);
      i_start = 1; checking = 1;
      @(negedge clk);
      chk({nm, "_start_lat"}, o_fwd_start, 1);
      seen = 0;
      for (int i = 0; i < 2000 && !seen; i++) begin
         @(negedge clk);
         seen = o_stop;
      end
      chk({nm, "_stop"}, seen, 1);
      repeat (3) @(negedge clk);
      chk({nm, "_hold_done"}, o_stop, 1);
      chk({nm, "_pulses_left"}, exp_p.size(), 0);
      chk({nm, "_costs_left"}, exp_c.size(), 0);
      chk({nm, "_epoch"}, o_epoch, exp_epoch);
      chk({nm, "_conv"}, o_converged, exp_conv);
      chk({nm, "_final_cost"}, o_cost, model_cost);
      i_start = 0;
      @(negedge clk);
      chk({nm, "_idle"}, {o_stop, o_busy}, 0);
      checking = 0;
   endtask

   initial begin
      bit any, seen;
      costs = '{100, -200, 300, -400};
      #12 rst_n = 1;
      @(negedge clk);
      chk("reset_outputs", outs(), 0);

      do_run("t1", 0, 3, 300, 0);
      chk("t1_cost", o_cost, 250);
      chk("t1_nvalid", cnt_v, 1);
      chk("t1_pulses", cnt_f * 10000 + cnt_b * 100 + cnt_u, 40404);
      chk("t1_epoch", o_epoch, 1);
      chk("t1_conv", o_converged, 1);

      do_run("t2", 0, 3, 100, 0);
      chk("t2_nvalid", cnt_v, 3);
      chk("t2_epoch", o_epoch, 3);
      chk("t2_conv", o_converged, 0);

      do_run("t3", 1, 3, 0, 0);
      chk("t3_pulses", cnt_f * 10000 + cnt_b * 100 + cnt_u, 40000);
      chk("t3_cost", o_cost, 250);
      chk("t3_epoch", o_epoch, 1);
      chk("t3_conv", o_converged, 0);

      costs = '{-8388608, -8388608, -8388608, -8388608};
      do_run("t4", 0, 5, 8388607, 0);
      chk("t4_cost", o_cost, 8388607);
      chk("t4_conv", o_converged, 1);

      // asynchronous reset in the middle of an update
      costs = '{100, -200, 300, -400};
      @(negedge clk);
      i_mode = 0; i_max_epochs = 3; i_cost_thresh = 0; i_start = 1;
      seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         seen = o_upd_start;
      end
      chk("t5_reach_upd", seen, 1);
      #2 rst_n = 0;
      #1 chk("t5_async_reset", outs(), 0);
      i_start = 0; model_cost = 0;
      @(negedge clk) rst_n = 1;
      @(negedge clk) #1 force_upd = 1;
      @(negedge clk) #1 force_upd = 0;
      any = 0;
      repeat (4) begin
         @(negedge clk);
         any |= o_busy | o_fwd_start | o_bwd_start | o_upd_start | o_stop;
      end
      chk("t5_idle_ignores_done", any, 0);

      do_run("t6", 0, 3, 100, 8);
      chk("t6_nvalid", cnt_v, 0);
      chk("t6_cost", o_cost, 0);
      chk("t6_conv", o_converged, 0);
      chk("t6_epoch", o_epoch, 0);

      do_run("t7", 0, 0, 100, 0);
      chk("t7_nvalid", cnt_v, 1);
      chk("t7_epoch", o_epoch, 1);
      chk("t7_cost", o_cost, 250);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/train_seq.md
# train_seq

Parametrised training sequencer for the DNN back-propagation datapath. Per sample it drives forward, backward and weight-update engines with start/done handshakes, and accumulates per-sample cost into an epoch mean. It stops on convergence, epoch limit or abort. It replaces the fixed single-mode control inside the top level and adds an inference-only mode, a configurable epoch limit and a cost threshold.

## Interface
- WIDTH, 24, signed fixed-point width of cost values
- LOG2_SAMPLES, 2, samples per epoch = 2**LOG2_SAMPLES
- ACC_WIDTH, 32, cost accumulator width (must be ≥ WIDTH+LOG2_SAMPLES)
- EPOCH_W, 16, epoch counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  level; run request
- i_abort  in  1  terminate the run
- i_mode  in  1  0 = train (fwd, bwd, upd); 1 = evaluate (fwd only, one epoch)
- i_max_epochs  in  EPOCH_W  epoch limit; 0 treated as 1
- i_cost_thresh  in  WIDTH  convergence threshold (signed, compared to mean cost)
- o_fwd_start / o_bwd_start / o_upd_start  out  1  one-cycle engine start pulses
- i_fwd_done / i_bwd_done / i_upd_done  in  1  engine completion pulses
- i_sample_cost  in  WIDTH  signed sample cost, valid when i_fwd_done=1
- o_sample_idx  out  LOG2_SAMPLES  current sample index
- o_epoch  out  EPOCH_W  completed epochs in this run
- o_cost  out  WIDTH  mean cost of last completed epoch
- o_cost_valid  out  1  one-cycle pulse when o_cost updates
- o_busy  out  1  high in any state except IDLE and DONE
- o_stop  out  1  high in DONE
- o_converged  out  1  valid with o_stop; 1 if stopped on threshold

## Operation
- States: IDLE, FWD, BWD, UPD, EPOCH, DONE.
- IDLE, i_start=1: latch i_mode, i_max_epochs, i_cost_thresh. Clear acc, o_sample_idx, o_epoch, o_converged. Go to FWD.
- Every entry into FWD/BWD/UPD registers the matching start pulse high for exactly the first cycle in that state.
- FWD: on i_fwd_done, acc += |i_sample_cost|. |−2^(WIDTH−1)| saturates to 2^(WIDTH−1)−1. Acc saturates at 2^(ACC_WIDTH−1)−1.
  - Train mode: go to BWD.
  - Eval mode: go to next sample, or EPOCH after the last sample.
- BWD: on i_bwd_done go to UPD.
- UPD: on i_upd_done go to FWD with o_sample_idx+1, or go to EPOCH if o_sample_idx = 2**LOG2_SAMPLES−1.
- Done pulses are ignored outside their own state. A done pulse in the same cycle as its start pulse is accepted.
- EPOCH (one cycle):
  - o_cost = acc >>> LOG2_SAMPLES, saturated to WIDTH; o_cost_valid pulses; o_epoch+1.
  - Clear acc; o_sample_idx = 0.
- EPOCH exit, using the new values, in priority order:
  - o_cost ≤ thresh → DONE with o_converged=1.
  - Eval mode, or o_epoch = max(i_max_epochs,1) → DONE with o_converged=0.
  - Otherwise → FWD.
- i_abort in FWD/BWD/UPD/EPOCH → DONE at next edge, o_converged=0. Abort overrides the EPOCH decision; o_cost still updates if aborting in EPOCH.
- DONE: o_stop=1. All outputs hold. Go to IDLE only when i_start=0, so a continuously held i_start does not rerun.
- o_epoch at EPOCH_W max: saturates; not reachable when the limit is respected.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE; all outputs 0, o_cost = 0.
- Reset mid-run: run lost immediately, no completion pulse; restart needs a new i_start.
- Start → o_fwd_start: i_start sampled high at edge k; o_fwd_start high in cycle k..k+1.
- Handshake latency: done at edge n → next start pulse in cycle n..n+1. Zero bubble cycles except EPOCH.
- Training epoch overhead: 1 EPOCH cycle + 3·2**LOG2_SAMPLES state cycles minimum.
- o_cost and o_cost_valid change on the edge leaving EPOCH; o_stop rises on the same edge when the run terminates there.

## Test plan
- Train, LOG2_SAMPLES=2, costs 100, −200, 300, −400, thresh 300, engines done 1 cycle after start → o_cost=250, one o_cost_valid, o_epoch=1, o_stop=1, o_converged=1, 12 start pulses in order fwd/bwd/upd.
- Same costs, thresh 100, i_max_epochs=3 → three o_cost_valid pulses of 250, o_epoch=3, o_converged=0; i_start held high keeps DONE; i_start low → IDLE next edge.
- Eval mode, same costs, thresh 0 → no bwd/upd pulses, 4 fwd pulses, o_cost=250, o_epoch=1, o_converged=0.
- Saturation: WIDTH=24, all costs −8388608 → o_cost=8388607, converged with thresh 8388607.
- i_abort during BWD of sample 2 → DONE next edge, no o_cost_valid, o_cost unchanged (0), o_converged=0; i_max_epochs=0 run stops after exactly 1 epoch.
- rst_n low mid-UPD, asynchronous (no clock edge) → all outputs 0 immediately; spurious i_upd_done in IDLE ignored; fresh i_start runs normally.
